// File: rtl/bus_scan_reader_pkg.sv
// Shared definitions for the tri-state bus scan reader: FSM state encoding
// and an index-width helper.
package bus_scan_reader_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GAP    = 2'd1,
        SELECT = 2'd2,
        HOLD   = 2'd3
    } scan_state_t;

    // Width of an index over n items, never less than one bit.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((64'd1 << w) < 64'(n)) w++;
        return w;
    endfunction

endpackage

// File: rtl/bus_select_decoder.sv
// Turns a source index plus enable into active-low one-hot chip selects;
// all selects stay released while disabled.
module bus_select_decoder #(
    parameter int unsigned NrOfSources = 4,
    parameter int unsigned IdxW        = 2
) (
    input  logic [IdxW-1:0]        i_idx,
    input  logic                   i_en,
    output logic [NrOfSources-1:0] o_cs
);

    always_comb begin
        o_cs = '1;
        for (int unsigned k = 0; k < NrOfSources; k++) begin
            if (i_en && (i_idx == k[IdxW-1:0])) o_cs[k] = 1'b0;
        end
    end

endmodule

// File: rtl/bus_scan_reader.sv
// Reader end of the shared tri-state register bus: selects each source in
// turn, waits the settle time, captures the word and hands it downstream.
module bus_scan_reader
    import bus_scan_reader_pkg::*;
#(
    parameter int unsigned NrOfBits     = 8,
    parameter int unsigned NrOfSources  = 4,
    parameter int unsigned SettleCycles = 1,
    parameter bit          ClearOnRead  = 1'b0
) (
    input  logic                                 Clock,
    input  logic                                 Reset,
    input  logic                                 Tick,
    input  logic                                 start,
    input  logic [NrOfBits-1:0]                  bus_in,
    output logic [NrOfSources-1:0]               cs,
    output logic [NrOfSources-1:0]               clr,
    output logic [NrOfBits-1:0]                  out_data,
    output logic [clog2(NrOfSources)-1:0]        out_index,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic                                 busy,
    output logic                                 done
);

    localparam int unsigned    IdxW       = clog2(NrOfSources);
    localparam logic [IdxW-1:0] LastIdx    = IdxW'(NrOfSources - 1);
    localparam logic [3:0]      SettleInit = 4'(SettleCycles);

    scan_state_t              r_state;
    logic [IdxW-1:0]          r_idx;
    logic [3:0]               r_cnt;
    logic [NrOfBits-1:0]      r_data;
    logic [IdxW-1:0]          r_index;
    logic                     r_valid;
    logic [NrOfSources-1:0]   r_clr;
    logic                     r_done;
    logic                     w_sel_en;

    // cs decodes straight from registered state, so reset releases the bus at once.
    assign w_sel_en = (r_state == SELECT);

    bus_select_decoder #(
        .NrOfSources (NrOfSources),
        .IdxW        (IdxW)
    ) u_decoder (
        .i_idx (r_idx),
        .i_en  (w_sel_en),
        .o_cs  (cs)
    );

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_data  <= '0;
            r_index <= '0;
            r_valid <= 1'b0;
            r_clr   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_clr  <= '0;
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (Tick && start) begin
                        r_state <= GAP;
                        r_idx   <= '0;
                    end
                end
                GAP: begin
                    if (Tick) begin
                        r_state <= SELECT;
                        r_cnt   <= SettleInit;
                    end
                end
                SELECT: begin
                    if (Tick) begin
                        if (r_cnt == 4'd1) begin
                            r_data  <= bus_in;
                            r_index <= r_idx;
                            r_valid <= 1'b1;
                            r_state <= HOLD;
                        end else begin
                            r_cnt <= r_cnt - 4'd1;
                        end
                    end
                end
                HOLD: begin
                    // Handshake completes regardless of Tick.
                    if (out_ready) begin
                        r_valid <= 1'b0;
                        if (ClearOnRead) r_clr[r_idx] <= 1'b1;
                        if (r_idx == LastIdx) begin
                            r_done  <= 1'b1;
                            r_idx   <= '0;
                            r_state <= IDLE;
                        end else begin
                            r_idx   <= r_idx + IdxW'(1);
                            r_state <= GAP;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign clr       = r_clr;
    assign out_data  = r_data;
    assign out_index = r_index;
    assign out_valid = r_valid;
    assign busy      = (r_state != IDLE);
    assign done      = r_done;

endmodule

// File: tb/tb_bus_scan_reader.sv
// Randomized bench for bus_scan_reader against a Tick-counting transaction
// model of the scan (GAP 1 Tick, SELECT SettleCycles Ticks, HOLD until accepted).
module tb_bus_scan_reader;

    localparam int unsigned NSRC   = 4;
    localparam int unsigned SETTLE = 3;
    localparam bit          CLR    = 1'b1;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       Tick = 1'b0;
    logic       start = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] bus_in;
    logic [3:0] cs;
    logic [3:0] clr;
    logic [7:0] out_data;
    logic [1:0] out_index;
    logic       out_valid;
    logic       busy;
    logic       done;

    logic [7:0] src [NSRC];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int done_seen = 0;

    bit         m_busy = 1'b0;
    bit         m_have = 1'b0;
    int         m_idx = 0;
    int         m_ticks = 0;
    logic [7:0] m_data = '0;
    logic [1:0] m_index = '0;

    bus_scan_reader #(
        .NrOfBits     (8),
        .NrOfSources  (NSRC),
        .SettleCycles (SETTLE),
        .ClearOnRead  (CLR)
    ) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .Tick      (Tick),
        .start     (start),
        .bus_in    (bus_in),
        .cs        (cs),
        .clr       (clr),
        .out_data  (out_data),
        .out_index (out_index),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    always #5 Clock = ~Clock;

    // Resolved bus: the selected source drives, a floating bus reads as pulled-up.
    always_comb begin
        bus_in = 8'hFF;
        for (int k = 0; k < NSRC; k++) begin
            if (cs[k] == 1'b0) bus_in = src[k];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy  = 1'b0;
        m_have  = 1'b0;
        m_idx   = 0;
        m_ticks = 0;
        m_data  = '0;
        m_index = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cs"}, cs, 4'hF);
        check({tag, "_valid"}, out_valid, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_clr"}, clr, 4'h0);
        check({tag, "_data"}, out_data, 8'h00);
        check({tag, "_index"}, out_index, 2'd0);
    endtask

    // Asserts Reset mid-cycle, checks the immediate effect, releases after one edge.
    task automatic apply_reset(input string tag);
        #3;
        Reset = 1'b1;
        #1;
        check_reset_outputs(tag);
        model_reset();
        @(posedge Clock);
        #1;
        cyc++;
        Reset = 1'b0;
    endtask

    // One clock edge with the inputs currently driven; the model advances on
    // the same edge and every output is compared afterwards.
    task automatic step();
        bit         t, rdy, st, e_done;
        logic [3:0] e_clr, e_cs;
        logic [7:0] cap;
        t = Tick; rdy = out_ready; st = start;
        e_done = 1'b0;
        e_clr = '0;
        cap = src[m_idx];
        if (!m_busy) begin
            if (t && st) begin
                m_busy = 1'b1; m_idx = 0; m_ticks = 0; m_have = 1'b0;
            end
        end else if (m_have) begin
            if (rdy) begin
                m_have = 1'b0;
                if (CLR) e_clr[m_idx] = 1'b1;
                if (m_idx == NSRC - 1) begin
                    e_done = 1'b1; m_busy = 1'b0; m_idx = 0;
                end else begin
                    m_idx++;
                end
                m_ticks = 0;
            end
        end else if (t) begin
            m_ticks++;
            if (m_ticks == SETTLE + 1) begin
                m_have  = 1'b1;
                m_data  = cap;
                m_index = 2'(m_idx);
            end
        end
        @(posedge Clock);
        #1;
        cyc++;
        e_cs = 4'hF;
        if (m_busy && !m_have && m_ticks >= 1) e_cs[m_idx] = 1'b0;
        check("valid", out_valid, m_have);
        check("busy", busy, m_busy);
        check("done", done, e_done);
        check("clr", clr, e_clr);
        check("cs", cs, e_cs);
        check("data", out_data, m_data);
        check("index", out_index, m_index);
        if (done === 1'b1) done_seen++;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        start = 1'b0; Tick = 1'b1; out_ready = 1'b1;
        n = 0;
        while (m_busy && n < 300) begin step(); n++; end
        check({tag, "_idle_timeout"}, m_busy, 1'b0);
    endtask

    initial begin
        int         n, stall, base, lat;
        logic [7:0] words [$];
        bit         hit;

        src[0] = 8'hA1; src[1] = 8'hB2; src[2] = 8'hC3; src[3] = 8'hD4;
        apply_reset("rst0");

        // Basic scan: Tick every clock, downstream always ready.
        Tick = 1'b1; out_ready = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        base = done_seen;
        words.delete();
        n = 0;
        while (done_seen == base && n < 200) begin
            if (out_valid && out_ready) words.push_back(out_data);
            step(); n++;
        end
        check("A_timeout", done_seen - base, 1);
        check("A_count", words.size(), 4);
        for (int i = 0; i < 4 && i < words.size(); i++) check("A_word", words[i], src[i]);
        for (int i = 0; i < 5; i++) step();
        check("A_done_once", done_seen - base, 1);

        // Sparse Tick: first word 1+SETTLE Ticks (4 clocks each) after start.
        n = 0;
        start = 1'b1; out_ready = 1'b1;
        while (!m_busy && n < 20) begin Tick = ((cyc + 1) % 4 == 0); step(); n++; end
        start = 1'b0;
        lat = 0;
        while (!out_valid && lat < 60) begin
            Tick = ((cyc + 1) % 4 == 0);
            if (m_busy && !m_have && m_ticks >= 1) src[m_idx] = 8'($urandom);
            step(); lat++;
        end
        check("B_first_valid_clks", lat, 4 * (SETTLE + 1));
        n = 0;
        while (m_busy && n < 400) begin
            Tick = ((cyc + 1) % 4 == 0);
            if (m_busy && !m_have && m_ticks >= 1 && $urandom_range(1) == 1) src[m_idx] = 8'($urandom);
            step(); n++;
        end
        check("B_timeout", m_busy, 1'b0);

        // Downstream stall of 10 clocks on source 1.
        src[0] = 8'hA1; src[1] = 8'hB2; src[2] = 8'hC3; src[3] = 8'hD4;
        Tick = 1'b1; start = 1'b1; stall = 0; n = 0;
        while (n < 300 && (n == 0 || m_busy)) begin
            out_ready = !(m_have && m_idx == 1 && stall < 10);
            if (!out_ready) begin
                stall++;
                check("C_stall_data", out_data, 8'hB2);
                check("C_stall_cs", cs, 4'hF);
            end
            step();
            start = 1'b0; n++;
        end
        check("C_stall_len", stall, 10);
        check("C_timeout", m_busy, 1'b0);

        // Random Tick, ready, start and source changes while selected.
        for (int i = 0; i < 800; i++) begin
            Tick      = ($urandom_range(2) != 0);
            out_ready = ($urandom_range(3) != 0);
            start     = ($urandom_range(4) == 0);
            if (m_busy && !m_have && m_ticks >= 1 && $urandom_range(2) == 0) src[m_idx] = 8'($urandom);
            step();
        end
        wait_idle("D");

        // Reset in the middle of selecting source 2, then a fresh scan.
        src[0] = 8'h11; src[1] = 8'h22; src[2] = 8'h33; src[3] = 8'h44;
        Tick = 1'b1; out_ready = 1'b1; start = 1'b1;
        hit = 1'b0; n = 0;
        while (!hit && n < 200) begin
            step(); start = 1'b0; n++;
            hit = (m_busy && !m_have && m_idx == 2 && m_ticks >= 1);
        end
        check("E_reach_sel2", hit, 1'b1);
        check("E_sel2_cs", cs, 4'hB);
        apply_reset("E_rst");
        check_reset_outputs("E_after");
        start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (!out_valid && n < 50) begin step(); n++; end
        check("E_first_index", out_index, 2'd0);
        check("E_first_data", out_data, 8'h11);
        wait_idle("E");

        // start held high: ignored while busy, next scan on the Tick after done.
        src[0] = 8'h5A; src[1] = 8'h6B; src[2] = 8'h7C; src[3] = 8'h8D;
        Tick = 1'b1; out_ready = 1'b1; start = 1'b1;
        base = done_seen;
        words.delete();
        n = 0;
        while (done_seen - base < 2 && n < 400) begin
            Tick = (n % 3 != 2);
            if (out_valid && out_ready) words.push_back(out_data);
            step(); n++;
        end
        start = 1'b0;
        check("F_scans", done_seen - base, 2);
        check("F_count", words.size(), 8);
        for (int i = 0; i < 8 && i < words.size(); i++) check("F_word", words[i], src[i % 4]);
        wait_idle("F");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bus_scan_reader.md
Name: bus_scan_reader

Overview:
- Reader end of the shared tri-state register bus. Each source register drives its value when its cs is low and floats (Z) when cs is high.
- This block selects sources one at a time and waits a settle time. It then captures the bus word and offers it downstream with a valid/ready handshake.
- Optionally pulses a per-source clear after each read (read-and-clear). Sits between the feature/result register bank and the classifier/readout logic.

Parameters:
- NrOfBits, 8, bus word width.
- NrOfSources, 4, number of tri-state sources on the bus (2..16).
- SettleCycles, 1, Tick cycles cs is held low before capture (1..15).
- ClearOnRead, 0, 1 = pulse clr[idx] after a source's word is accepted.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Tick  in  1  clock-enable strobe; FSM advances only on edges with Tick=1.
- start  in  1  begin one full scan; sampled in IDLE only.
- bus_in  in  NrOfBits  shared tri-state bus (resolved value).
- cs  out  NrOfSources  per-source release, active-low select; at most one bit low.
- clr  out  NrOfSources  per-source clear pulse, one Clock wide, active-high.
- out_data  out  NrOfBits  captured word.
- out_index  out  clog2(NrOfSources)  source index of out_data.
- out_valid  out  1  out_data/out_index valid.
- out_ready  in  1  downstream accepts when high with out_valid.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-Clock pulse when the last source is accepted.

Behaviour:
Reset (async, immediate), with IDLE and idx=0:
- cs = all ones.
- clr = 0; out_data = 0; out_index = 0.
- out_valid = 0; busy = 0; done = 0.

Reset during a scan:
- Immediately releases the bus; no partial word is ever presented.

FSM states: IDLE, GAP, SELECT, HOLD.
- IDLE: on edge with Tick & start, go to GAP, idx=0, busy=1.
- GAP: all cs high for exactly 1 Tick (break-before-make), then SELECT and load settle counter = SettleCycles.
- SELECT: cs[idx]=0, all other cs=1.
  - Counter decrements each Tick.
  - On the Tick where counter==1: out_data<=bus_in, out_index<=idx, out_valid<=1, cs[idx]<=1 on the same edge, go to HOLD.
- HOLD: cs all high; out_valid held and out_data stable.
  - Transfer occurs on any rising edge with out_valid & out_ready, independent of Tick.
  - On transfer, out_valid<=0 on the same edge.
  - If ClearOnRead: clr[idx]=1 for that single Clock.
  - If idx==NrOfSources-1: done=1 for that Clock, go to IDLE, idx=0.
  - Otherwise: idx+1, go to GAP.
- start while busy is ignored; start held high in IDLE restarts a scan on the next Tick after done.

Latency:
- Per source, 1 + SettleCycles Ticks from GAP entry to out_valid, plus downstream stall.
- First out_valid appears 1+SettleCycles Ticks after start is accepted.

Invariants:
- Never two cs bits low at once.
- cs never low outside SELECT.
- out_data changes only on capture.

Index wrap:
- idx never exceeds NrOfSources-1.
- out_index width is clog2(NrOfSources), minimum 1.

Tick low:
- FSM, counter and cs hold.
- Handshake in HOLD still completes.

Decomposition:
- Shared package: state encoding constants (IDLE=2'd0, GAP=2'd1, SELECT=2'd2, HOLD=2'd3) and a clog2 function.
- One natural sub-module, bus_select_decoder: idx plus an enable in, active-low one-hot cs out, all ones when disabled.
- Settle counter and FSM stay in the top module.

Test Plan:
- Reset then idle, 4 sources driving 8'hA1, 8'hB2, 8'hC3, 8'hD4, Tick=1, out_ready=1, start pulse:
  - out_valid 4 times with (0,A1), (1,B2), (2,C3), (3,D4).
  - done pulses once, busy falls the same cycle.
  - cs shows 1110, 1111, 1101, 1111, ... and never two bits low.
- SettleCycles=3, Tick every 4th Clock: first out_valid appears exactly 4 Ticks (16 Clocks) after start accepted; capture is correct if bus_in changes before the capture edge.
- out_ready low for 10 cycles on source 1:
  - out_valid and out_data=B2 stay stable, cs stays 1111.
  - The scan resumes one GAP Tick after acceptance.
- ClearOnRead=1: clr[k] pulses exactly one Clock, coincident with acceptance of source k; no clr occurs while cs[k] is low.
- Reset asserted mid-SELECT of source 2: cs=1111 and out_valid=0 asynchronously; after release the block is IDLE, and a new start gives index 0 first.
- start held high through a scan: ignored while busy; a second scan begins on the first Tick after done and returns the same 4 words.
